// File: rtl/cpu_registers.sv
// 6502-style register file: A/X/Y/SP/PC, address latches, flags and store-data mux.
// Registered updates on rising clk (sync active-high reset, stall freezes all state); data is combinational.
module cpu_registers (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dest_sel,
    input  logic [7:0]  pc_sel,
    input  logic [7:0]  sp_sel,
    input  logic [7:0]  ld_sel,
    input  logic [7:0]  st_sel,
    input  logic [7:0]  int_sel,
    input  logic        clr_adh,
    input  logic        clr_bah,
    input  logic [7:0]  alu_out,
    input  logic [7:0]  next_status,
    input  logic        stall,
    output logic [7:0]  data,
    output logic [7:0]  a,
    output logic [7:0]  x,
    output logic [7:0]  y,
    output logic [7:0]  ir,
    output logic [7:0]  imm,
    output logic [7:0]  adv,
    output logic [7:0]  bav,
    output logic [7:0]  offset,
    output logic [7:0]  sp,
    output logic [15:0] pc,
    output logic [15:0] ad,
    output logic [15:0] ba,
    output logic        n,
    output logic        z,
    output logic        v,
    output logic        c,
    output logic        b,
    output logic        d,
    output logic        i,
    output logic [7:0]  status
);

    logic [7:0]  r_a, r_x, r_y, r_ir, r_imm, r_adv, r_bav, r_offset, r_sp, r_status;
    logic [15:0] r_pc, r_ad, r_ba;

    logic [15:0] w_pc_next, w_ad_next, w_ba_next;
    logic [7:0]  w_sp_next;
    logic        w_flags_ld;

    always_comb begin
        w_pc_next = r_pc;
        case (pc_sel)
            8'd1:    w_pc_next = r_ad;
            8'd2:    w_pc_next = r_ad + 16'd1;
            8'd3:    w_pc_next = r_pc + 16'd1;
            8'd5:    w_pc_next = {alu_out, r_adv};
            8'd6:    w_pc_next = {r_bav, r_adv};
            8'd7:    w_pc_next = r_ad + {8'h00, r_bav};
            8'd8:    w_pc_next = 16'h0000;
            8'd11:   w_pc_next = {r_ir, r_imm};
            8'd12:   w_pc_next = {r_adv, r_imm};
            8'd13: begin
                case (int_sel)
                    8'd0:    w_pc_next = 16'hFFFA;
                    8'd1:    w_pc_next = 16'hFFFC;
                    default: w_pc_next = 16'hFFFE;
                endcase
            end
            8'd14:   w_pc_next = r_pc + {{8{r_offset[7]}}, r_offset};
            default: w_pc_next = r_pc;
        endcase
    end

    // SP sources in priority order: datapath write, explicit sp_sel, then pc_sel=4 increment.
    always_comb begin
        w_sp_next = r_sp;
        if (dest_sel == 8'd4)
            w_sp_next = alu_out;
        else if (sp_sel == 8'd1)
            w_sp_next = r_sp + 8'd1;
        else if (sp_sel == 8'd2)
            w_sp_next = r_sp - 8'd1;
        else if (pc_sel == 8'd4)
            w_sp_next = r_sp + 8'd1;
    end

    // High-byte clears win over a same-cycle byte load.
    always_comb begin
        w_ad_next[7:0]  = (ld_sel == 8'd3) ? alu_out : r_ad[7:0];
        w_ad_next[15:8] = (clr_adh || pc_sel == 8'd9) ? 8'h00 :
                          (ld_sel == 8'd4) ? alu_out : r_ad[15:8];
        w_ba_next[7:0]  = (ld_sel == 8'd5) ? alu_out : r_ba[7:0];
        w_ba_next[15:8] = (clr_bah || pc_sel == 8'd10) ? 8'h00 :
                          (ld_sel == 8'd6) ? alu_out : r_ba[15:8];
    end

    assign w_flags_ld = (dest_sel == 8'd1) || (dest_sel == 8'd2) ||
                        (dest_sel == 8'd3) || (dest_sel == 8'd5);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= 16'h0000;
            r_ad     <= 16'h0000;
            r_ba     <= 16'h0000;
            r_a      <= 8'h00;
            r_x      <= 8'h00;
            r_y      <= 8'h00;
            r_ir     <= 8'h00;
            r_imm    <= 8'h00;
            r_adv    <= 8'h00;
            r_bav    <= 8'h00;
            r_offset <= 8'h00;
            r_sp     <= 8'hFD;
            r_status <= 8'h24;
        end else if (!stall) begin
            r_pc <= w_pc_next;
            r_sp <= w_sp_next;
            r_ad <= w_ad_next;
            r_ba <= w_ba_next;
            if (dest_sel == 8'd1) r_a <= alu_out;
            if (dest_sel == 8'd2) r_x <= alu_out;
            if (dest_sel == 8'd3) r_y <= alu_out;
            if (w_flags_ld) r_status <= next_status | 8'h20;
            if (ld_sel == 8'd1) r_ir     <= alu_out;
            if (ld_sel == 8'd2) r_imm    <= alu_out;
            if (ld_sel == 8'd7) r_adv    <= alu_out;
            if (ld_sel == 8'd8) r_bav    <= alu_out;
            if (ld_sel == 8'd9) r_offset <= alu_out;
        end
    end

    always_comb begin
        case (st_sel)
            8'd1:    data = r_a;
            8'd2:    data = r_x;
            8'd3:    data = r_y;
            8'd4:    data = r_pc[7:0];
            8'd5:    data = r_pc[15:8];
            8'd6:    data = r_status | 8'h30;
            8'd7:    data = r_status & 8'hEF;
            default: data = 8'h00;
        endcase
    end

    assign a      = r_a;
    assign x      = r_x;
    assign y      = r_y;
    assign ir     = r_ir;
    assign imm    = r_imm;
    assign adv    = r_adv;
    assign bav    = r_bav;
    assign offset = r_offset;
    assign sp     = r_sp;
    assign pc     = r_pc;
    assign ad     = r_ad;
    assign ba     = r_ba;
    assign status = r_status;
    assign n      = r_status[7];
    assign v      = r_status[6];
    assign b      = r_status[4];
    assign d      = r_status[3];
    assign i      = r_status[2];
    assign z      = r_status[1];
    assign c      = r_status[0];

endmodule

// File: tb/tb_cpu_registers.sv
// Directed bench for cpu_registers: one task per feature, hand-computed expectations.
module tb_cpu_registers;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dest_sel, pc_sel, sp_sel, ld_sel, st_sel, int_sel;
    logic        clr_adh, clr_bah, stall;
    logic [7:0]  alu_out, next_status;
    logic [7:0]  data, a, x, y, ir, imm, adv, bav, offset, sp, status;
    logic [15:0] pc, ad, ba;
    logic        n, z, v, c, b, d, i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_registers dut (
        .clk(clk), .rst(rst),
        .dest_sel(dest_sel), .pc_sel(pc_sel), .sp_sel(sp_sel), .ld_sel(ld_sel),
        .st_sel(st_sel), .int_sel(int_sel), .clr_adh(clr_adh), .clr_bah(clr_bah),
        .alu_out(alu_out), .next_status(next_status), .stall(stall),
        .data(data), .a(a), .x(x), .y(y), .ir(ir), .imm(imm), .adv(adv), .bav(bav),
        .offset(offset), .sp(sp), .pc(pc), .ad(ad), .ba(ba),
        .n(n), .z(z), .v(v), .c(c), .b(b), .d(d), .i(i), .status(status)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dest_sel = 0; pc_sel = 0; sp_sel = 0; ld_sel = 0; st_sel = 0; int_sel = 0;
        clr_adh = 0; clr_bah = 0; stall = 0; alu_out = 0; next_status = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step(); step();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
        checks++; if (sp !== 8'hFD) begin errors++; $display("FAIL reset_sp got %h exp FD", sp); end
        checks++; if (status !== 8'h24) begin errors++; $display("FAIL reset_status got %h exp 24", status); end
        checks++; if ({i, n, z, v, c, b, d} !== 7'b1000000) begin errors++; $display("FAIL reset_flags got %b exp 1000000", {i, n, z, v, c, b, d}); end
        checks++; if ({a, x, y, ad, ba} !== 56'h0) begin errors++; $display("FAIL reset_regs got %h exp 0", {a, x, y, ad, ba}); end
        rst = 0;
    endtask

    task automatic test_pc_inc();
        pc_sel = 3; step(); pc_sel = 0;
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL pc_inc got %h exp 0001", pc); end
        checks++; if (status !== 8'h24) begin errors++; $display("FAIL pc_inc_status got %h exp 24", status); end
        checks++; if (sp !== 8'hFD) begin errors++; $display("FAIL pc_inc_sp got %h exp FD", sp); end
    endtask

    task automatic test_ad_jump();
        ld_sel = 3; alu_out = 8'h34; step();
        ld_sel = 4; alu_out = 8'h12; step();
        ld_sel = 0;
        checks++; if (ad !== 16'h1234) begin errors++; $display("FAIL ad_load got %h exp 1234", ad); end
        pc_sel = 1; step();
        checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL pc_from_ad got %h exp 1234", pc); end
        pc_sel = 2; step(); pc_sel = 0;
        checks++; if (pc !== 16'h1235) begin errors++; $display("FAIL pc_ad_plus1 got %h exp 1235", pc); end
    endtask

    task automatic test_vector();
        pc_sel = 13; int_sel = 0; step();
        checks++; if (pc !== 16'hFFFA) begin errors++; $display("FAIL vec0 got %h exp FFFA", pc); end
        int_sel = 2; step();
        checks++; if (pc !== 16'hFFFE) begin errors++; $display("FAIL vec2 got %h exp FFFE", pc); end
        int_sel = 1; step();
        checks++; if (pc !== 16'hFFFC) begin errors++; $display("FAIL vec1 got %h exp FFFC", pc); end
        int_sel = 0; pc_sel = 3;
        for (int k = 0; k < 4; k++) step();
        pc_sel = 0;
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h exp 0000", pc); end
    endtask

    task automatic test_branch();
        ld_sel = 9; alu_out = 8'hFE; step();
        ld_sel = 3; alu_out = 8'h10; step();
        ld_sel = 4; alu_out = 8'h00; step();
        ld_sel = 0; pc_sel = 1; step();
        checks++; if (offset !== 8'hFE) begin errors++; $display("FAIL offset_load got %h exp FE", offset); end
        pc_sel = 14; step();
        checks++; if (pc !== 16'h000E) begin errors++; $display("FAIL branch_back got %h exp 000E", pc); end
        stall = 1; pc_sel = 3; dest_sel = 1; alu_out = 8'h77; next_status = 8'hFF; step();
        checks++; if (pc !== 16'h000E) begin errors++; $display("FAIL stall_pc got %h exp 000E", pc); end
        checks++; if (a !== 8'h00 || status !== 8'h24) begin errors++; $display("FAIL stall_a_status got %h/%h exp 00/24", a, status); end
        stall = 0; dest_sel = 0; next_status = 0;
        pc_sel = 0; ld_sel = 9; alu_out = 8'h02; step();
        ld_sel = 0; pc_sel = 14; step(); pc_sel = 0;
        checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL branch_fwd got %h exp 0010", pc); end
    endtask

    task automatic test_flags();
        dest_sel = 1; alu_out = 8'h80; next_status = 8'h80; step();
        dest_sel = 0;
        checks++; if (a !== 8'h80 || n !== 1'b1) begin errors++; $display("FAIL lda_a_n got %h/%b exp 80/1", a, n); end
        checks++; if (status !== 8'hA0) begin errors++; $display("FAIL lda_status got %h exp A0", status); end
        st_sel = 1; #1;
        checks++; if (data !== 8'h80) begin errors++; $display("FAIL st_a got %h exp 80", data); end
        st_sel = 6; #1;
        checks++; if (data !== 8'hB0) begin errors++; $display("FAIL st_php got %h exp B0", data); end
        st_sel = 0;
        dest_sel = 5; next_status = 8'hDF; alu_out = 8'h11; step();
        dest_sel = 0;
        checks++; if (status !== 8'hFF || a !== 8'h80) begin errors++; $display("FAIL flags_only got %h/%h exp FF/80", status, a); end
        st_sel = 7; #1;
        checks++; if (data !== 8'hEF) begin errors++; $display("FAIL st_brk_clr got %h exp EF", data); end
        dest_sel = 2; alu_out = 8'h11; next_status = 8'h02; step();
        dest_sel = 3; alu_out = 8'h22; next_status = 8'h01; step();
        dest_sel = 0;
        checks++; if (x !== 8'h11 || y !== 8'h22) begin errors++; $display("FAIL ldx_ldy got %h/%h exp 11/22", x, y); end
        checks++; if (status !== 8'h21 || c !== 1'b1 || z !== 1'b0) begin errors++; $display("FAIL bit5_forced got %h exp 21", status); end
        st_sel = 2; #1;
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL st_x got %h exp 11", data); end
        st_sel = 3; #1;
        checks++; if (data !== 8'h22) begin errors++; $display("FAIL st_y got %h exp 22", data); end
        st_sel = 4; #1;
        checks++; if (data !== 8'h10) begin errors++; $display("FAIL st_pcl got %h exp 10", data); end
        st_sel = 9; #1;
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL st_none got %h exp 00", data); end
        st_sel = 0; next_status = 0;
    endtask

    task automatic test_sp();
        sp_sel = 1; step(); step(); sp_sel = 0;
        checks++; if (sp !== 8'hFF) begin errors++; $display("FAIL sp_inc got %h exp FF", sp); end
        pc_sel = 4; step();
        checks++; if (sp !== 8'h00 || pc !== 16'h0010) begin errors++; $display("FAIL sp_wrap got %h/%h exp 00/0010", sp, pc); end
        pc_sel = 8; step();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL pc_zero got %h exp 0000", pc); end
        pc_sel = 0; dest_sel = 4; sp_sel = 1; alu_out = 8'h55; next_status = 8'h00; step();
        checks++; if (sp !== 8'h55 || status !== 8'h21) begin errors++; $display("FAIL txs_prio got %h/%h exp 55/21", sp, status); end
        dest_sel = 0; sp_sel = 2; pc_sel = 4; step();
        sp_sel = 0; pc_sel = 0;
        checks++; if (sp !== 8'h54) begin errors++; $display("FAIL sp_dec_prio got %h exp 54", sp); end
    endtask

    task automatic test_addr_regs();
        ld_sel = 4; alu_out = 8'hAB; clr_adh = 1; step();
        clr_adh = 0;
        checks++; if (ad !== 16'h0010) begin errors++; $display("FAIL clr_adh got %h exp 0010", ad); end
        step();
        checks++; if (ad !== 16'hAB10) begin errors++; $display("FAIL adh_load got %h exp AB10", ad); end
        ld_sel = 0; pc_sel = 9; step(); pc_sel = 0;
        checks++; if (ad !== 16'h0010 || pc !== 16'h0000) begin errors++; $display("FAIL pcsel9 got %h/%h exp 0010/0000", ad, pc); end
        ld_sel = 6; alu_out = 8'hCD; step();
        ld_sel = 5; alu_out = 8'h44; clr_bah = 1; step();
        clr_bah = 0; ld_sel = 6; alu_out = 8'h99; clr_bah = 1; step();
        clr_bah = 0;
        checks++; if (ba !== 16'h0044) begin errors++; $display("FAIL clr_bah got %h exp 0044", ba); end
        alu_out = 8'h12; step();
        ld_sel = 0; pc_sel = 10; step(); pc_sel = 0;
        checks++; if (ba !== 16'h0044) begin errors++; $display("FAIL pcsel10 got %h exp 0044", ba); end
        ld_sel = 7; alu_out = 8'h34; step();
        ld_sel = 8; alu_out = 8'hF0; step();
        ld_sel = 1; alu_out = 8'h56; step();
        ld_sel = 2; alu_out = 8'h78; step();
        ld_sel = 0; pc_sel = 6; step();
        checks++; if (pc !== 16'hF034) begin errors++; $display("FAIL pc_bav_adv got %h exp F034", pc); end
        pc_sel = 7; step();
        checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL pc_ad_bav got %h exp 0100", pc); end
        pc_sel = 5; alu_out = 8'h9A; step();
        checks++; if (pc !== 16'h9A34) begin errors++; $display("FAIL pc_alu_adv got %h exp 9A34", pc); end
        pc_sel = 11; step();
        checks++; if (pc !== 16'h5678) begin errors++; $display("FAIL pc_ir_imm got %h exp 5678", pc); end
        pc_sel = 12; step();
        checks++; if (pc !== 16'h3478) begin errors++; $display("FAIL pc_adv_imm got %h exp 3478", pc); end
        pc_sel = 15; step(); pc_sel = 0;
        checks++; if (pc !== 16'h3478) begin errors++; $display("FAIL pc_hold15 got %h exp 3478", pc); end
    endtask

    task automatic test_reset_mid();
        stall = 1; pc_sel = 3; dest_sel = 1; sp_sel = 1; ld_sel = 7; alu_out = 8'hEE; rst = 1;
        step();
        rst = 0; idle();
        checks++; if (pc !== 16'h0000 || sp !== 8'hFD) begin errors++; $display("FAIL rst_mid_pc_sp got %h/%h exp 0000/FD", pc, sp); end
        checks++; if (a !== 8'h00 || status !== 8'h24 || adv !== 8'h00 || ad !== 16'h0000) begin errors++; $display("FAIL rst_mid_regs got %h/%h/%h/%h exp 00/24/00/0000", a, status, adv, ad); end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_pc_inc();
        test_ad_jump();
        test_vector();
        test_branch();
        test_flags();
        test_sp();
        test_addr_regs();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_registers.md
CPU_REGISTERS -- requirements
Module: cpu_registers

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-002 Port: clk  in  1  clock.
REQ-003 Port: rst  in  1  synchronous active-high reset.
REQ-004 Ports: dest_sel, pc_sel, sp_sel, ld_sel, st_sel, int_sel  in  8 each  operation selects; unlisted codes = no-op.
REQ-005 Ports: clr_adh, clr_bah  in  1 each  clear high byte of ad / ba.
REQ-006 Ports: alu_out  in  8  write/load datapath value; next_status  in  8  next flag vector (N V - B D I Z C).
REQ-007 Port: stall  in  1  freeze all registers.
REQ-008 Port: data  out  8  store data, combinational per st_sel.
REQ-009 Ports: a, x, y, ir, imm, adv, bav, offset, sp  out  8 each  register contents.
REQ-010 Ports: pc, ad, ba  out  16 each  program counter, address, base address.
REQ-011 Ports: n, z, v, c, b, d, i  out  1 each  flag bits; status  out  8  {n,v,1,b,d,i,z,c}.

Function
REQ-012 Write precedence per edge: rst > stall > normal update; stall=1 holds every register.
REQ-013 dest_sel (value = alu_out): 1 A, 2 X, 3 Y, 4 SP; codes 1-3 also load flags from next_status; 5 loads flags only from next_status; 0/others none.
REQ-014 Status bit 5 SHALL always read 1 regardless of next_status.
REQ-015 ld_sel (value = alu_out): 1 IR, 2 IMM, 3 ad[7:0], 4 ad[15:8], 5 ba[7:0], 6 ba[15:8], 7 ADV, 8 BAV, 9 OFFSET; others none.
REQ-016 clr_adh=1 clears ad[15:8]; clr_bah=1 clears ba[15:8]; each overrides an ld_sel write to the same byte in that cycle.
REQ-017 pc_sel: 0 hold; 1 pc<=ad; 2 pc<=ad+1; 3 pc<=pc+1; 4 sp<=sp+1, pc holds; 5 pc<={alu_out,adv}; 6 pc<={bav,adv}.
REQ-018 pc_sel: 7 pc<=ad+{8'h00,bav}; 8 pc<=0; 9 ad[15:8]<=0, pc holds; 10 ba[15:8]<=0, pc holds; 11 pc<={ir,imm}; 12 pc<={adv,imm}.
REQ-019 pc_sel 13 pc<=vector by int_sel: 0 16'hFFFA, 1 16'hFFFC, 2+ 16'hFFFE.
REQ-020 pc_sel 14 pc<=pc+sign-extended offset; pc_sel 15 and 16-255 hold.
REQ-021 All 16-bit and 8-bit arithmetic wraps modulo 2^16 / 2^8 (pc FFFF+1=0000, sp FF+1=00).
REQ-022 sp_sel: 1 sp<=sp+1, 2 sp<=sp-1; others hold; SP precedence: dest_sel=4 > sp_sel > pc_sel=4.
REQ-023 st_sel -> data: 1 A, 2 X, 3 Y, 4 pc[7:0], 5 pc[15:8], 6 status|8'h30, 7 status with bit4=0, others 8'h00.
REQ-024 Flag outputs and status are direct register reads; no output latency beyond the registering edge.

Reset
REQ-025 On rst=1 at an edge: pc=16'h0000, a=x=y=ir=imm=adv=bav=offset=0, ad=ba=0, sp=8'hFD.
REQ-026 Reset flags: i=1, others 0; status=8'h24. Reset overrides stall and all selects, including mid-operation.

Verification
REQ-027 Reset then release, pc_sel=3 for one cycle -> pc=16'h0001; status=8'h24; sp=8'hFD.
REQ-028 ld_sel=3 alu_out=34, ld_sel=4 alu_out=12, pc_sel=1 -> pc=16'h1234; pc_sel=2 -> pc=16'h1235.
REQ-029 pc_sel=13, int_sel=1 -> pc=16'hFFFC; then pc_sel=3 four times -> pc=16'h0000 (wrap).
REQ-030 offset=8'hFE via ld_sel=9, pc=16'h0010, pc_sel=14 -> pc=16'h000E; stall=1 with pc_sel=3 -> pc unchanged.
REQ-031 dest_sel=1 alu_out=8'h80 next_status=8'h80 -> a=8'h80, n=1, status=8'hA0; st_sel=1 -> data=8'h80.
REQ-032 pc_sel=4 with sp=8'hFF -> sp=8'h00, pc unchanged; pc_sel=8 -> pc=16'h0000.
